// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a prefetch FIFO and
// serializes each one as a back-to-back UART frame.
module fifo_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       rd_clk,
  input  logic       rd_rst,
  input  logic       fifo_rd_vld,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  input  logic       tx_enable,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] LP_RELOAD = 16'(CLK_DIV - 1);
  localparam logic LP_LAST_STOP = (STOP_BITS == 2);
  localparam logic LP_PAR_EN    = (PARITY_EN != 0);
  localparam logic LP_PAR_ODD   = (PARITY_ODD != 0);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic        r_stop, w_stop_nxt;
  logic [7:0]  r_shreg, w_shreg_nxt;
  logic        r_par, w_par_nxt;
  logic        r_txd, w_txd_nxt;
  logic        w_tick, w_last, w_pop;

  assign w_tick = (r_cnt == 16'd0);
  assign w_last = (r_state == S_STOP) && w_tick &&
                  (r_stop == LP_LAST_STOP);
  assign w_pop  = tx_enable && fifo_rd_vld &&
                  ((r_state == S_IDLE) || w_last);

  // Gate with reset so the strobe drops without waiting for a clock
  assign fifo_rd_en = w_pop && !rd_rst;
  assign tx_done    = w_last;
  assign tx_busy    = (r_state != S_IDLE);
  assign uart_txd   = r_txd;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_stop_nxt  = r_stop;
    w_shreg_nxt = r_shreg;
    w_par_nxt   = r_par;
    w_txd_nxt   = 1'b1;
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_tick ? LP_RELOAD : r_cnt - 16'd1;
    end
    case (r_state)
      S_IDLE: begin
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shreg_nxt = {1'b0, r_shreg[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = LP_PAR_EN ? S_PARITY : S_STOP;
            w_stop_nxt  = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt = S_STOP;
          w_stop_nxt  = 1'b0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_last) w_state_nxt = S_IDLE;
          else        w_stop_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A pop overrides the end-of-frame return to idle
    if (w_pop) begin
      w_state_nxt = S_START;
      w_cnt_nxt   = LP_RELOAD;
      w_shreg_nxt = fifo_rd_data;
      w_par_nxt   = (^fifo_rd_data) ^ LP_PAR_ODD;
    end
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shreg_nxt[0];
      S_PARITY: w_txd_nxt = w_par_nxt;
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_stop  <= 1'b0;
      r_shreg <= 8'd0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_stop  <= w_stop_nxt;
      r_shreg <= w_shreg_nxt;
      r_par   <= w_par_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three UART configurations checked every
// cycle against a frame-position model, plus literal checks.
module tb_fifo_uart_tx;

  localparam int N    = 3;
  localparam int CD   = 4;
  localparam int MAXC = 4096;
  localparam int PEN [N] = '{0, 1, 1};
  localparam int POD [N] = '{0, 1, 0};
  localparam int STB [N] = '{1, 2, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       gmode;
  logic       vld  [N];
  logic [7:0] dat  [N];
  logic       rden [N];
  logic       txd  [N];
  logic       busy [N];
  logic       done [N];
  logic       gate [N];

  logic [7:0] q [N][$];
  int         pops  [N][$];
  int         dones [N][$];
  logic       h_txd [N][0:MAXC-1];

  logic       m_act [N];
  int         m_pos [N];
  logic [7:0] m_byte[N];
  logic       m_pop [N];
  logic [7:0] m_dat [N];
  logic       seen  [N];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLK_DIV(CD), .PARITY_EN(0),
                 .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .rd_clk(clk), .rd_rst(rst),
    .fifo_rd_vld(vld[0]), .fifo_rd_data(dat[0]),
    .fifo_rd_en(rden[0]), .tx_enable(en),
    .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  fifo_uart_tx #(.CLK_DIV(CD), .PARITY_EN(1),
                 .PARITY_ODD(1), .STOP_BITS(2)) u1 (
    .rd_clk(clk), .rd_rst(rst),
    .fifo_rd_vld(vld[1]), .fifo_rd_data(dat[1]),
    .fifo_rd_en(rden[1]), .tx_enable(en),
    .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  fifo_uart_tx #(.CLK_DIV(CD), .PARITY_EN(1),
                 .PARITY_ODD(0), .STOP_BITS(2)) u2 (
    .rd_clk(clk), .rd_rst(rst),
    .fifo_rd_vld(vld[2]), .fifo_rd_data(dat[2]),
    .fifo_rd_en(rden[2]), .tx_enable(en),
    .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  function automatic int flen(input int i);
    return (10 + PEN[i] + STB[i] - 1) * CD;
  endfunction

  // Frame bit by position: start, 8 data LSB first, parity, stops
  function automatic logic fbit(input int i, input logic [7:0] b,
                                input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PEN[i] != 0 && idx == 9) return (^b) ^ (POD[i] != 0);
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%b exp=%b", nm, i, cyc, a, e);
    end
  endtask

  task automatic chki(input string nm, input int i,
                      input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0d exp=%0d", nm, i, cyc, a, e);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic e_en, e_txd, e_busy, e_done;
      if (rst) m_act[i] = 1'b0;
      e_busy = m_act[i];
      e_done = m_act[i] && (m_pos[i] == flen(i) - 1);
      e_en   = !rst && en && vld[i] && (!m_act[i] || e_done);
      e_txd  = m_act[i] ? fbit(i, m_byte[i], m_pos[i] / CD) : 1'b1;
      chk("rd_en", i, rden[i], e_en);
      chk("txd",   i, txd[i],  e_txd);
      chk("busy",  i, busy[i], e_busy);
      chk("done",  i, done[i], e_done);
      m_pop[i] = e_en;
      m_dat[i] = dat[i];
      seen[i]  = rden[i];
      if (cyc < MAXC) h_txd[i][cyc] = txd[i];
      if (rden[i] === 1'b1) pops[i].push_back(cyc);
      if (done[i] === 1'b1) dones[i].push_back(cyc);
    end
  end

  always begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst) m_act[i] = 1'b0;
      else if (m_pop[i]) begin
        m_act[i]  = 1'b1;
        m_pos[i]  = 0;
        m_byte[i] = m_dat[i];
      end else if (m_act[i]) begin
        if (m_pos[i] == flen(i) - 1) m_act[i] = 1'b0;
        else m_pos[i]++;
      end
      if (seen[i] && q[i].size() > 0) void'(q[i].pop_front());
    end
    #1;
    for (int i = 0; i < N; i++) begin
      gate[i] = gmode ? ($urandom_range(0, 3) != 0) : 1'b1;
      vld[i]  = (q[i].size() > 0) && gate[i];
      dat[i]  = (q[i].size() > 0) ? q[i][0] : 8'($urandom);
    end
  end

  function automatic logic active();
    for (int i = 0; i < N; i++)
      if (q[i].size() > 0 || busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int p, p2, n0;
    logic [7:0] b;
    rst = 1'b1; en = 1'b0; gmode = 1'b0;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; dat[i] = 8'h00; gate[i] = 1'b1;
      m_act[i] = 1'b0; m_pos[i] = 0; m_pop[i] = 1'b0;
      m_byte[i] = 8'h00; m_dat[i] = 8'h00; seen[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_txd",  0, txd[0],  1'b1);
    chk("rst_busy", 0, busy[0], 1'b0);
    chk("rst_done", 0, done[0], 1'b0);
    chk("rst_en",   0, rden[0], 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < N; i++) q[i].push_back(i == 0 ? 8'h55 : 8'h07);
    repeat (100) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) chki("gate_pops", i, pops[i].size(), 0);
    chk("gate_txd", 0, txd[0], 1'b1);

    @(posedge clk); #1 en = 1'b1;
    repeat (70) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) chki("single_pops", i, pops[i].size(), 1);
    p = pops[0][0];
    chki("len_a", 0, dones[0][0] - p, 40);
    for (int j = 0; j < 10; j++)
      chk("bits55", j, h_txd[0][p+1+4*j+2], 1'(j % 2));
    chk("busy_end", 0, busy[0], 1'b0);
    p = pops[1][0];
    chki("len_b", 1, dones[1][0] - p, 48);
    chk("par_odd", 1, h_txd[1][p+1+36+2], 1'b0);
    p = pops[2][0];
    chki("len_c", 2, dones[2][0] - p, 48);
    chk("par_even", 2, h_txd[2][p+1+36+2], 1'b1);

    n0 = pops[0].size();
    q[0].push_back(8'hA5);
    q[0].push_back(8'h3C);
    repeat (100) @(posedge clk);
    #2;
    chki("b2b_pops", 0, pops[0].size(), n0 + 2);
    p = pops[0][n0];
    chki("b2b_gap", 0, pops[0][n0+1] - p, 40);
    chk("b2b_stop", 0, h_txd[0][p+40], 1'b1);
    chk("b2b_start", 0, h_txd[0][p+41], 1'b0);

    n0 = pops[0].size();
    for (int k = 0; k < 3; k++) q[0].push_back(8'($urandom));
    for (int k = 0; k < 20 && pops[0].size() == n0; k++) begin
      @(posedge clk); #2;
    end
    chki("drop_wait", 0, pops[0].size(), n0 + 1);
    repeat (10) @(posedge clk);
    #1 en = 1'b0;
    repeat (80) @(posedge clk);
    #2;
    chki("drop_pops", 0, pops[0].size(), n0 + 1);
    chk("drop_busy", 0, busy[0], 1'b0);
    en = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    chki("drain_pops", 0, pops[0].size(), n0 + 3);

    n0 = pops[0].size();
    q[0].push_back(8'hC3);
    for (int k = 0; k < 20 && pops[0].size() == n0; k++) begin
      @(posedge clk); #2;
    end
    chki("rst_wait", 0, pops[0].size(), n0 + 1);
    p = pops[0][pops[0].size()-1];
    do begin @(posedge clk); #1; end while (cyc < p + 18);
    rst = 1'b1;
    #1;
    chk("arst_txd",  0, txd[0],  1'b1);
    chk("arst_busy", 0, busy[0], 1'b0);
    chk("arst_en",   0, rden[0], 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    b = 8'h96;
    q[0].push_back(b);
    repeat (60) @(posedge clk);
    #2;
    chki("post_rst_pops", 0, pops[0].size(), n0 + 2);
    p2 = pops[0][pops[0].size()-1];
    chk("post_start", 0, h_txd[0][p2+1+2], 1'b0);
    for (int j = 0; j < 8; j++)
      chk("post_bits", j, h_txd[0][p2+1+4*(j+1)+2], b[j]);

    n0 = pops[0].size();
    repeat (100) @(posedge clk);
    #2;
    chki("empty_pops", 0, pops[0].size(), n0);
    chk("empty_busy", 0, busy[0], 1'b0);

    gmode = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 15) == 0)
        q[$urandom_range(0, N-1)].push_back(8'($urandom));
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
    end
    en = 1'b1;
    gmode = 1'b0;
    for (int k = 0; k < 20000 && active(); k++) @(posedge clk);
    #2;
    chk("drain_all", 0, active(), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
